// File: rtl/mux_pkg_sefunmi.sv
// Constants and state encoding shared by the 8:1 mux datapath.
// The upstream mux and the deserializer both import this package.
package mux_pkg_sefunmi;

    localparam int FRAME_BITS = 8;
    localparam int IDX_W      = 3;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    typedef logic [FRAME_BITS-1:0] frame_t;
    typedef logic [IDX_W-1:0]      idx_t;

endpackage

// File: rtl/demux1to8_sefunmi.sv
// 1-to-WIDTH decoder: turns a bit index into one-hot write enables
// for the deserializer shadow register.
module demux1to8_sefunmi #(
    parameter int WIDTH = mux_pkg_sefunmi::FRAME_BITS,
    parameter int IDX_W = mux_pkg_sefunmi::IDX_W
) (
    input  logic             enable,
    input  logic [IDX_W-1:0] select,
    output logic [WIDTH-1:0] wr_en
);

    always_comb begin
        wr_en = '0;
        for (int i = 0; i < WIDTH; i++) begin
            wr_en[i] = enable && (select == IDX_W'(i));
        end
    end

endmodule

// File: rtl/deserializer8_sefunmi.sv
// Serial-to-parallel receiver: rebuilds bytes sent LSB first by the
// upstream 8:1 mux and presents them on a valid/ready output.
module deserializer8_sefunmi #(
    parameter int WIDTH = mux_pkg_sefunmi::FRAME_BITS,
    parameter int IDX_W = mux_pkg_sefunmi::IDX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic             serial_in,
    input  logic             out_ready,
    output logic [WIDTH-1:0] par_out,
    output logic             out_valid,
    output logic [IDX_W-1:0] select,
    output logic             overrun
);

    import mux_pkg_sefunmi::*;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);

    logic [0:0]       state_q,   state_d;
    logic [IDX_W-1:0] select_q,  select_d;
    logic [WIDTH-1:0] shadow_q,  shadow_d;
    logic [WIDTH-1:0] par_q,     par_d;
    logic             valid_q,   valid_d;
    logic             overrun_q, overrun_d;

    logic             begin_frame;
    logic             advance;
    logic             complete;
    logic             wr_go;
    logic [IDX_W-1:0] wr_idx;
    logic [WIDTH-1:0] wr_en;

    // A start always wins, in IDLE or mid-frame, and lands on bit 0.
    assign begin_frame = enable && start;
    assign advance     = enable && !start && (state_q == SHIFT);
    assign complete    = advance && (select_q == LAST);
    assign wr_go       = begin_frame || advance;
    assign wr_idx      = begin_frame ? '0 : select_q;

    demux1to8_sefunmi #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_demux (
        .enable (wr_go),
        .select (wr_idx),
        .wr_en  (wr_en)
    );

    always_comb begin
        state_d   = state_q;
        select_d  = select_q;
        shadow_d  = shadow_q;
        par_d     = par_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        if (begin_frame) begin
            shadow_d = '0;
            select_d = IDX_W'(1);
            state_d  = SHIFT;
        end else if (advance && !complete) begin
            select_d = select_q + IDX_W'(1);
        end

        for (int i = 0; i < WIDTH; i++) begin
            if (wr_en[i]) begin
                shadow_d[i] = serial_in;
            end
        end

        // Last bit bypasses the shadow so the byte is out one edge sooner.
        if (complete) begin
            par_d    = {serial_in, shadow_q[WIDTH-2:0]};
            valid_d  = 1'b1;
            select_d = '0;
            state_d  = IDLE;
            if (valid_q && !out_ready) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            select_q  <= '0;
            shadow_q  <= '0;
            par_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            select_q  <= select_d;
            shadow_q  <= shadow_d;
            par_q     <= par_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign par_out   = par_q;
    assign out_valid = valid_q;
    assign select    = select_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_deserializer8_sefunmi.sv
// Scoreboard bench: the driver queues expected bytes, a monitor
// pops one whenever a new frame appears on par_out.
module tb_deserializer8_sefunmi;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       start;
    logic       serial_in;
    logic       out_ready;
    logic [7:0] par_out;
    logic       out_valid;
    logic [2:0] select;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int frames   = 0;

    logic [7:0] exp_q[$];
    logic       prev_valid = 1'b0;
    logic [7:0] prev_par   = 8'h00;

    deserializer8_sefunmi dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .start     (start),
        .serial_in (serial_in),
        .out_ready (out_ready),
        .par_out   (par_out),
        .out_valid (out_valid),
        .select    (select),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // New frame: valid rises, or par_out changes while valid (overrun).
    always @(negedge clk) begin
        if (out_valid && (!prev_valid || par_out != prev_par)) begin
            frames++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL frame: got %0h expected none", par_out);
            end else begin
                check("frame", {24'h0, par_out}, {24'h0, exp_q.pop_front()});
            end
        end
        prev_valid = out_valid;
        prev_par   = par_out;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic st);
        serial_in = b;
        start     = st;
        enable    = 1'b1;
        tick();
        enable    = 1'b0;
        start     = 1'b0;
    endtask

    task automatic idle(input int n);
        enable = 1'b0;
        start  = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_bits(input logic [7:0] v, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            send_bit(v[i], i == 0);
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
    endtask

    int f0;

    initial begin
        reset = 1'b1;
        repeat (2) begin
            enable    = 1'($urandom);
            start     = 1'($urandom);
            serial_in = 1'($urandom);
            out_ready = 1'($urandom);
            tick();
        end
        check("rst_par", {24'h0, par_out}, 32'h00);
        check("rst_valid", {31'h0, out_valid}, 32'h0);
        check("rst_select", {29'h0, select}, 32'h0);
        check("rst_overrun", {31'h0, overrun}, 32'h0);
        reset = 1'b0;
        enable = 1'b0;
        start = 1'b0;
        serial_in = 1'b0;
        out_ready = 1'b0;
        idle(1);

        // Single frame, latency WIDTH edges from start
        exp_q.push_back(8'hAA);
        send_bits(8'hAA, 0, 6);
        check("single_pre", {31'h0, out_valid}, 32'h0);
        check("single_sel7", {29'h0, select}, 32'h7);
        send_bits(8'hAA, 7, 7);
        check("single_valid", {31'h0, out_valid}, 32'h1);
        check("single_sel0", {29'h0, select}, 32'h0);
        idle(1);
        check("single_hold", {31'h0, out_valid}, 32'h1);
        consume();
        check("single_taken", {31'h0, out_valid}, 32'h0);

        // Stall at select=4 for three cycles
        exp_q.push_back(8'hAA);
        send_bits(8'hAA, 0, 3);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check("stall_sel", {29'h0, select}, 32'h4);
        end
        send_bits(8'hAA, 4, 6);
        check("stall_pre", {31'h0, out_valid}, 32'h0);
        send_bits(8'hAA, 7, 7);
        check("stall_valid", {31'h0, out_valid}, 32'h1);
        consume();

        // Back-to-back frames without consumption
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        send_bits(8'hAA, 0, 7);
        check("ovr_first", {31'h0, overrun}, 32'h0);
        send_bits(8'h55, 0, 7);
        check("ovr_valid", {31'h0, out_valid}, 32'h1);
        check("ovr_flag", {31'h0, overrun}, 32'h1);
        consume();
        check("ovr_taken", {31'h0, out_valid}, 32'h0);
        check("ovr_sticky", {31'h0, overrun}, 32'h1);

        // Restart mid-frame: 0xFF abandoned, 0x3C delivered once
        f0 = frames;
        exp_q.push_back(8'h3C);
        send_bits(8'hFF, 0, 3);
        check("rs_sel4", {29'h0, select}, 32'h4);
        send_bit(1'b0, 1'b1);
        check("rs_sel1", {29'h0, select}, 32'h1);
        send_bits(8'h3C, 1, 6);
        check("rs_pre", {31'h0, out_valid}, 32'h0);
        send_bits(8'h3C, 7, 7);
        check("rs_valid", {31'h0, out_valid}, 32'h1);
        consume();
        check("rs_one_frame", frames - f0, 32'h1);

        // Reset mid-frame while a frame is pending
        exp_q.push_back(8'h5A);
        send_bits(8'h5A, 0, 7);
        send_bits(8'hFF, 0, 4);
        check("mr_sel5", {29'h0, select}, 32'h5);
        check("mr_valid", {31'h0, out_valid}, 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mr_sel", {29'h0, select}, 32'h0);
        check("mr_valid0", {31'h0, out_valid}, 32'h0);
        check("mr_par", {24'h0, par_out}, 32'h00);
        check("mr_overrun", {31'h0, overrun}, 32'h0);
        exp_q.push_back(8'h81);
        send_bits(8'h81, 0, 7);
        check("mr_next_valid", {31'h0, out_valid}, 32'h1);
        check("mr_next_ovr", {31'h0, overrun}, 32'h0);
        consume();

        idle(3);
        check("queue_empty", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
